btn_debounce_toggle: RTL and testbench
======================================

# btn_debounce_toggle

Button-conditioning stage that sits directly upstream of the 8-LED shift stage and drives its `check` input. It synchronizes a raw mechanical push-button, rejects bounce with a stable-sample counter, and converts each accepted press into a one-cycle pulse and a toggled `check` level. It runs on the undivided board clock, not on the divided shift clock, so `check` is a clean quasi-static level by the time the slow shift stage samples it.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive identical synchronized samples required to accept a level change; 20 ms at 50 MHz; legal range 2 to 2^CNT_W−1.
- `CNT_W`, default 20: debounce counter width.
- `clk` input 1: board clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset. `reset`=0 clears all state immediately; release is taken on a `clk` edge.
- `btn_raw` input 1: asynchronous push-button, 1 = pressed.
- `btn_level` output 1: debounced button level.
- `press_pulse` output 1: high for exactly one `clk` cycle per accepted press.
- `check` output 1: toggle level, inverted on each accepted press; feeds the shift stage.

## Operation
- **Synchronizer.** Two-flop synchronizer `btn_raw` → `s1` → `btn_s`. Only `btn_s` is used downstream.
- **FSM states.** IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE.
  - IDLE: if `btn_s`=1, go to WAIT_PRESS with cnt=1; otherwise stay with cnt=0.
  - WAIT_PRESS:
    - If `btn_s`=0, go to IDLE with cnt=0 (glitch rejected).
    - Else if cnt==DEBOUNCE_CYCLES−1, go to PRESSED with cnt=0.
    - Else cnt+1.
  - PRESSED: if `btn_s`=0, go to WAIT_RELEASE with cnt=1; otherwise hold.
  - WAIT_RELEASE:
    - If `btn_s`=1, return to PRESSED with cnt=0.
    - Else if cnt==DEBOUNCE_CYCLES−1, go to IDLE with cnt=0.
    - Else cnt+1.
- **Outputs.** All outputs are registered.
  - `btn_level`=1 in PRESSED and WAIT_RELEASE.
  - `press_pulse` is set only on the WAIT_PRESS→PRESSED transition.
  - `check` is inverted on that same transition.
  - Releases never produce a pulse or a toggle.
- **Counter.** cnt never exceeds DEBOUNCE_CYCLES−1 and never wraps.
- **Mid-stream abort.** Any opposing sample during a WAIT state aborts that wait and discards the count.
- **Held button.** A held button produces exactly one pulse, regardless of how long it is held.
- **Reset values.**
  - State=IDLE, cnt=0, `s1`=`btn_s`=0.
  - `btn_level`=0, `press_pulse`=0, `check`=0.
- **Reset mid-operation.** Asserting reset in any state, including while `press_pulse`=1, forces all of the reset values immediately. No toggle is pending after reset is released.

## Timing
- **Press latency.** `btn_raw` rises before edge 0 with setup met and then stays high. `btn_level`, `press_pulse` and `check` all change after edge DEBOUNCE_CYCLES+1.
- **Pulse width.** `press_pulse` falls after the next edge.
- **Release latency.** Measured the same way: `btn_level` falls after edge DEBOUNCE_CYCLES+1 from the last high sample.
- **Glitch rejection.**
  - A `btn_raw` pulse yielding fewer than DEBOUNCE_CYCLES consecutive high `btn_s` samples causes no output change.
  - A release bounce yielding fewer than DEBOUNCE_CYCLES consecutive low `btn_s` samples also causes no output change.
- **Minimum press-to-press spacing.** 2·DEBOUNCE_CYCLES+2 cycles.
- **Downstream sampling.** `check` is stable for at least 2·DEBOUNCE_CYCLES cycles between toggles. The downstream divided clock therefore samples it glitch-free, and no handshake is required.

## Configuration
- `BTN_ACTIVE_LOW_EN`
  - Defined: `btn_raw` is inverted before the first synchronizer flop, for pull-up buttons where 0 = pressed. The reset value of `s1`/`btn_s` becomes 0 post-inversion, i.e. the raw input is treated as idle-high.
  - Undefined: `btn_raw`=1 means pressed.
  - All FSM and output behaviour is identical in both cases.

## Test plan
Every scenario uses DEBOUNCE_CYCLES=4 and the macro undefined, unless noted.
- **Reset values.** Hold `reset`=0 for 3 cycles with `btn_raw`=1 → `btn_level`=0, `press_pulse`=0, `check`=0 throughout.
- **Clean press.** Clean press with `btn_raw` high from edge 0 for 20 cycles:
  - `btn_level` and `check` go to 1 after edge 5.
  - `press_pulse`=1 only between edges 5 and 6.
  - No further pulse while held.
  - Release, then after 5 edges `btn_level`=0 and `check` stays 1.
- **Bounce.** Bounce pattern 1,0,1,1,0,1 followed by a steady 1:
  - No output change during the bounce.
  - Exactly one `press_pulse`, 5 edges after the first steady-1 sample enters.
  - `check`=1.
- **Release bounce.** A 2-cycle low glitch while PRESSED → `btn_level` stays 1 with no pulse. A second clean press after a full release → `check` returns to 0.
- **Reset mid-pulse.** Assert `reset`=0 in the cycle where `press_pulse`=1 → all outputs are 0 immediately. After release with `btn_raw` still high, a new pulse occurs 5 edges later.
- **Active-low build.** With `BTN_ACTIVE_LOW_EN` defined, drive `btn_raw`=0 steadily for 10 cycles → one `press_pulse` and `check`=1. Driving `btn_raw`=1 causes no pulse.

Source files
------------

// File: rtl/btn_debounce_toggle.sv
// Push-button conditioner: 2-flop synchronizer, stable-sample debounce FSM, press pulse and toggle.
// Optional macro BTN_ACTIVE_LOW_EN inverts btn_raw ahead of the synchronizer (pull-up buttons).
module btn_debounce_toggle #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic check
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             w_btn_in;
  logic             r_s1;
  logic             r_btn_s;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             r_pulse;
  logic             r_check;
  logic             w_level_nxt;
  logic             w_pulse_nxt;
  logic             w_check_nxt;

`ifdef BTN_ACTIVE_LOW_EN
  assign w_btn_in = ~btn_raw;
`else
  assign w_btn_in = btn_raw;
`endif

  // Synchronizer stage: btn_raw -> r_s1 -> r_btn_s
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1    <= 1'b0;
      r_btn_s <= 1'b0;
    end else begin
      r_s1    <= w_btn_in;
      r_btn_s <= r_s1;
    end
  end

  // FSM / output register stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
      r_check <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_pulse <= w_pulse_nxt;
      r_check <= w_check_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pulse_nxt = 1'b0;
    w_check_nxt = r_check;
    unique case (r_state)
      IDLE: begin
        if (r_btn_s) begin
          w_state_nxt = WAIT_PRESS;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!r_btn_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
          w_pulse_nxt = 1'b1;
          w_check_nxt = ~r_check;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!r_btn_s) begin
          w_state_nxt = WAIT_RELEASE;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_RELEASE: begin
        // A high sample here is release bounce: fall back to PRESSED without any pulse
        if (r_btn_s) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    w_level_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == WAIT_RELEASE);
  end

  assign btn_level   = r_level;
  assign press_pulse = r_pulse;
  assign check       = r_check;

endmodule

// File: tb/tb_btn_debounce_toggle.sv
// Directed bench for btn_debounce_toggle with DEBOUNCE_CYCLES=4; stimulus is expressed as
// "pressed" and mapped onto btn_raw polarity according to BTN_ACTIVE_LOW_EN.
module tb_btn_debounce_toggle;

  localparam int D = 4;
`ifdef BTN_ACTIVE_LOW_EN
  localparam logic ACT_LOW = 1'b1;
`else
  localparam logic ACT_LOW = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_raw = 1'b0;
  logic btn_level;
  logic press_pulse;
  logic check;

  int n_chk = 0;
  int n_err = 0;

  btn_debounce_toggle #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .press_pulse(press_pulse),
    .check      (check)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic outs(input string tag, input logic el, input logic ep, input logic ec);
    chk({tag, ".level"}, {31'd0, btn_level}, {31'd0, el});
    chk({tag, ".pulse"}, {31'd0, press_pulse}, {31'd0, ep});
    chk({tag, ".check"}, {31'd0, check}, {31'd0, ec});
  endtask

  // Apply one sample (1 = pressed) ahead of the next rising edge, return on the falling edge.
  task automatic step(input logic pressed);
    btn_raw = pressed ^ ACT_LOW;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    btn_raw = 1'b0 ^ ACT_LOW;
    @(posedge clk);
    @(negedge clk);
    outs("rst", 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  logic [13:0] pat;

  initial begin
    pat = 14'b11111111101101;

    // Reset held with the button pressed
    reset   = 1'b0;
    btn_raw = 1'b1 ^ ACT_LOW;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      outs("reset_hold", 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;

    // Clean press: outputs change after edge D+1, single pulse while held
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      outs($sformatf("press_e%0d", i), i >= D + 1, i == D + 1, i >= D + 1);
    end
    for (int j = 0; j < 8; j++) begin
      step(1'b0);
      outs($sformatf("release_e%0d", j), j < D + 1, 1'b0, 1'b1);
    end

    // Press bounce 1,0,1,1,0,1 then steady 1: pulse 5 edges after steady run begins (edge 10)
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(pat[i]);
      outs($sformatf("bounce_e%0d", i), i >= 10, i == 10, i >= 10);
    end

    // Release bounce: 2-cycle low glitch while pressed is ignored
    for (int k = 0; k < 10; k++) begin
      step(k >= 2);
      outs($sformatf("relglitch_e%0d", k), 1'b1, 1'b0, 1'b1);
    end
    for (int j = 0; j < 8; j++) begin
      step(1'b0);
      outs($sformatf("release2_e%0d", j), j < D + 1, 1'b0, 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      outs($sformatf("press2_e%0d", i), i >= D + 1, i == D + 1, i < D + 1);
    end

    // Reset asserted while press_pulse is high
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      outs($sformatf("midpulse_e%0d", i), i >= D + 1, i == D + 1, i >= D + 1);
    end
    reset = 1'b0;
    #1;
    outs("midpulse_async", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    outs("midpulse_held", 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      outs($sformatf("repress_e%0d", i), i >= D + 1, i == D + 1, i >= D + 1);
    end

    // Opposite polarity on btn_raw must never look like a press
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      outs($sformatf("idle_pol_e%0d", i), 1'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
